grid_renderer: RTL

//  Read-side consumer of the tetris grid memory. Scans a 640x480@60 VGA raster and fetches one grid cell
//  per pixel tick over the memory's second (read-only) port. Maps each 8-bit block code to an RGB332 colour.

---
 rtl/grid_renderer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/grid_renderer.sv
// grid_renderer
//   Read-side consumer of the tetris grid memory. Walks a VGA raster at
//   half the system clock rate, fetches one grid cell per pixel tick over
//   the memory's read-only port, and turns each 8-bit block code into an
//   RGB332 colour for the DAC pins. It never writes the memory; tearing
//   against grid-controller writes within a frame is tolerated.
//
// Ports
//   clk            system clock (pixel rate is clk/2)
//   reset          synchronous, active-high
//   rd_addr_o      grid memory read address, registered (row*GRID_COLS+col)
//   rd_en_o        read strobe, high only for fetches inside the grid area
//   rd_data_i      grid memory read data, valid one clk after rd_addr_o
//   hsync_o        horizontal sync, active-low
//   vsync_o        vertical sync, active-low
//   rgb_o          pixel colour {R[2:0],G[2:0],B[1:0]}
//   frame_start_o  one-clk pulse while pixel (0,0) is driven on rgb_o
module grid_renderer #(
    parameter int CELL_SHIFT = 4,
    parameter int GRID_COLS  = 12,
    parameter int GRID_ROWS  = 20,
    parameter int X_ORIGIN   = 224,
    parameter int Y_ORIGIN   = 80,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] rd_addr_o,
    output logic       rd_en_o,
    input  logic [7:0] rd_data_i,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic [7:0] rgb_o,
    output logic       frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] X_LO      = 10'(X_ORIGIN);
    localparam logic [9:0] X_HI      = 10'(X_ORIGIN + (GRID_COLS << CELL_SHIFT));
    localparam logic [9:0] Y_LO      = 10'(Y_ORIGIN);
    localparam logic [9:0] Y_HI      = 10'(Y_ORIGIN + (GRID_ROWS << CELL_SHIFT));
    localparam logic [9:0] CELL_MASK = 10'((1 << CELL_SHIFT) - 1);
    localparam logic [7:0] COLS8     = 8'(GRID_COLS);

    // Pixel-rate enable and raster position
    logic       pixEn_q;
    logic [9:0] hCnt_q, hCnt_d;
    logic [9:0] vCnt_q, vCnt_d;

    // Stage A: fetch issue plus everything needed to colour the pixel later
    logic [7:0] rdAddr_q, rdAddr_d;
    logic       rdEn_q, rdEn_d;
    logic       activeA_q, activeA_d;
    logic       inGridA_q;
    logic       edgeA_q, edgeA_d;
    logic       hsA_q, hsA_d;
    logic       vsA_q, vsA_d;
    logic       originA_q, originA_d;

    // Stage B: registered pins
    logic       hsync_q;
    logic       vsync_q;
    logic [7:0] rgb_q, rgb_d;
    logic       frameStart_q, frameStart_d;

    logic [9:0] hOff, vOff;
    logic [7:0] cellCol, cellRow;

    // Pixel enable simply toggles; the first clk out of reset is a non-tick.
    always_ff @(posedge clk) begin
        if (reset) pixEn_q <= 1'b0;
        else       pixEn_q <= ~pixEn_q;
    end

    // Raster counters: h wraps at end of line, v advances on that wrap.
    always_comb begin
        hCnt_d = hCnt_q;
        vCnt_d = vCnt_q;
        if (hCnt_q == H_LAST) begin
            hCnt_d = 10'd0;
            vCnt_d = (vCnt_q == V_LAST) ? 10'd0 : vCnt_q + 10'd1;
        end else begin
            hCnt_d = hCnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hCnt_q <= 10'd0;
            vCnt_q <= 10'd0;
        end else if (pixEn_q) begin
            hCnt_q <= hCnt_d;
            vCnt_q <= vCnt_d;
        end
    end

    // Stage A decode. Offsets wrap when outside the grid, but they are only
    // used when inGrid holds, so the wrap is harmless.
    always_comb begin
        hOff      = hCnt_q - X_LO;
        vOff      = vCnt_q - Y_LO;
        cellCol   = 8'(hOff >> CELL_SHIFT);
        cellRow   = 8'(vOff >> CELL_SHIFT);
        rdEn_d    = (hCnt_q >= X_LO) && (hCnt_q < X_HI) &&
                    (vCnt_q >= Y_LO) && (vCnt_q < Y_HI);
        // Constant multiply reduces to shift-and-add ((row<<3)+(row<<2) for 12).
        rdAddr_d  = rdEn_d ? (cellRow * COLS8 + cellCol) : rdAddr_q;
        activeA_d = (hCnt_q < H_ACT) && (vCnt_q < V_ACT);
        edgeA_d   = ((hOff & CELL_MASK) == 10'd0) || ((vOff & CELL_MASK) == 10'd0);
        hsA_d     = !((hCnt_q >= HS_START) && (hCnt_q < HS_END));
        vsA_d     = !((vCnt_q >= VS_START) && (vCnt_q < VS_END));
        originA_d = (hCnt_q == 10'd0) && (vCnt_q == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdAddr_q  <= 8'd0;
            rdEn_q    <= 1'b0;
            activeA_q <= 1'b0;
            inGridA_q <= 1'b0;
            edgeA_q   <= 1'b0;
            hsA_q     <= 1'b1;
            vsA_q     <= 1'b1;
            originA_q <= 1'b0;
        end else if (pixEn_q) begin
            rdAddr_q  <= rdAddr_d;
            rdEn_q    <= rdEn_d;
            activeA_q <= activeA_d;
            inGridA_q <= rdEn_d;
            edgeA_q   <= edgeA_d;
            hsA_q     <= hsA_d;
            vsA_q     <= vsA_d;
            originA_q <= originA_d;
        end
    end

    // Stage B colour lookup: memory data arrived on the intervening non-tick
    // clk. Empty cells get a faint outline on their first row and column.
    always_comb begin
        rgb_d = 8'h00;
        if (activeA_q && inGridA_q) begin
            case (rd_data_i)
                8'd0:    rgb_d = edgeA_q ? 8'h24 : 8'h00;
                8'd1:    rgb_d = 8'h1F;
                8'd2:    rgb_d = 8'hFC;
                8'd3:    rgb_d = 8'hA3;
                8'd4:    rgb_d = 8'h1C;
                8'd5:    rgb_d = 8'hE0;
                8'd6:    rgb_d = 8'h03;
                8'd7:    rgb_d = 8'hF0;
                8'd8:    rgb_d = 8'h92;
                default: rgb_d = 8'hE3;
            endcase
        end
        // frame_start must last a single clk, so it drops on the non-tick clk.
        frameStart_d = pixEn_q ? originA_q : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= 8'h00;
        end else if (pixEn_q) begin
            hsync_q <= hsA_q;
            vsync_q <= vsA_q;
            rgb_q   <= rgb_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) frameStart_q <= 1'b0;
        else       frameStart_q <= frameStart_d;
    end

    assign rd_addr_o     = rdAddr_q;
    assign rd_en_o       = rdEn_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign rgb_o         = rgb_q;
    assign frame_start_o = frameStart_q;

endmodule
